// File: rtl/drap_pkg.sv
// Shared constants and state encoding for the DRAP instruction-fetch stage.
package drap_pkg;
   localparam int DRAP_AW = 7;
   localparam int DRAP_DW = 32;
   localparam logic [DRAP_AW-1:0] DRAP_RESET_PC = 7'd0;
   localparam int FB_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2
   } ifetch_state_t;
endpackage

// File: rtl/drap_ifetch_if.sv
// Memory, redirect and decode-handshake signals of the fetch stage.
// IFETCH_BOOTLOAD_EN adds the bootloader write port.
interface drap_ifetch_if
   import drap_pkg::*;
#(
   parameter int AW = DRAP_AW,
   parameter int DW = DRAP_DW
);
   logic [AW-1:0] imem_address;
   logic          imem_write;
   logic [DW-1:0] imem_data_in;
   logic [DW-1:0] imem_data_out;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
`ifdef IFETCH_BOOTLOAD_EN
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
`endif

   modport master (
      output imem_address, imem_write, imem_data_in, instr_valid, instr, instr_pc,
`ifdef IFETCH_BOOTLOAD_EN
      input  load_en, load_addr, load_data,
`endif
      input  imem_data_out, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_address, imem_write, imem_data_in, instr_valid, instr, instr_pc,
`ifdef IFETCH_BOOTLOAD_EN
      output load_en, load_addr, load_data,
`endif
      output imem_data_out, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/drap_fetch_buf.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// Head outputs read as zero while empty.
module drap_fetch_buf #(
   parameter int AW = 7,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic          valid_o,
   output logic [AW-1:0] head_pc_o,
   output logic [DW-1:0] head_data_o,
   output logic [1:0]    count_o
);
   logic [AW-1:0] pc_q   [2];
   logic [DW-1:0] data_q [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_i & (count_q != 2'd0);
   // A push into a full buffer is only legal when the head leaves on the same edge.
   assign do_push = push_i & ~flush_i & ((count_q != 2'd2) | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_q[wr_ptr_q]   <= push_pc_i;
         data_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign valid_o     = (count_q != 2'd0);
   assign head_pc_o   = valid_o ? pc_q[rd_ptr_q]   : '0;
   assign head_data_o = valid_o ? data_q[rd_ptr_q] : '0;
   assign count_o     = count_q;
endmodule

// File: rtl/drap_ifetch.sv
// Instruction-fetch stage: PC, issue/kill control and fetch buffer for DRAP_Imemory.
// IFETCH_BOOTLOAD_EN enables the bootloader path (load_en/load_addr/load_data).
module drap_ifetch
   import drap_pkg::*;
#(
   parameter int            AW       = DRAP_AW,
   parameter int            DW       = DRAP_DW,
   parameter logic [AW-1:0] RESET_PC = DRAP_RESET_PC
)(
   input  logic          clk,
   input  logic          reset,
   drap_ifetch_if.master bus
);
   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_FETCH = 2'(FETCH);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic          hold, redir, flush, push, pop, issue;
   logic [2:0]    occ, lim;
   logic [1:0]    fb_count;
   logic          fb_valid;
   logic [AW-1:0] fb_pc;
   logic [DW-1:0] fb_data;
   logic [AW-1:0] fetch_addr;

`ifdef IFETCH_BOOTLOAD_EN
   localparam logic [1:0] ST_LOAD = 2'(LOAD);
   // The falling-edge cycle (still in LOAD) also holds, so restart goes through IDLE.
   assign hold              = bus.load_en | (state_q == ST_LOAD);
   assign bus.imem_address  = bus.load_en ? bus.load_addr : fetch_addr;
   assign bus.imem_write    = bus.load_en;
   assign bus.imem_data_in  = bus.load_en ? bus.load_data : '0;
`else
   assign hold              = 1'b0;
   assign bus.imem_address  = fetch_addr;
   assign bus.imem_write    = 1'b0;
   assign bus.imem_data_in  = '0;
`endif

   assign pop   = fb_valid & bus.instr_ready;
   assign redir = bus.redirect_valid & ~hold;
   assign flush = redir | hold;
   assign push  = inflight_q & ~flush;
   // A same-cycle pop frees a slot, which keeps one issue per cycle in steady state.
   assign occ   = {1'b0, fb_count} + {2'b00, inflight_q};
   assign lim   = 3'(FB_DEPTH) + {2'b00, pop};
   assign issue = ~hold & ~redir & (occ < lim);

   assign fetch_addr = redir ? bus.redirect_pc : pc_q;

   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      if (hold) begin
         pc_d = RESET_PC;
      end else if (redir) begin
         pc_d       = bus.redirect_pc + AW'(1);
         req_pc_d   = bus.redirect_pc;
         inflight_d = 1'b1;
      end else if (issue) begin
         pc_d       = pc_q + AW'(1);
         req_pc_d   = pc_q;
         inflight_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: state_d = ST_FETCH;
`ifdef IFETCH_BOOTLOAD_EN
         ST_LOAD:  if (!bus.load_en) state_d = ST_IDLE;
`endif
         default:  state_d = ST_IDLE;
      endcase
`ifdef IFETCH_BOOTLOAD_EN
      if (bus.load_en) state_d = ST_LOAD;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   drap_fetch_buf #(.AW(AW), .DW(DW)) u_fb (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_pc_i   (req_pc_q),
      .push_data_i (bus.imem_data_out),
      .pop_i       (pop),
      .flush_i     (flush),
      .valid_o     (fb_valid),
      .head_pc_o   (fb_pc),
      .head_data_o (fb_data),
      .count_o     (fb_count)
   );

   assign bus.instr_valid = fb_valid;
   assign bus.instr_pc    = fb_pc;
   assign bus.instr       = fb_data;
endmodule

// File: tb/tb_drap_ifetch.sv
// Directed bench for drap_ifetch with a synchronous 128x32 memory model.
// IFETCH_BOOTLOAD_EN additionally exercises the bootloader path.
module tb_drap_ifetch;
   import drap_pkg::*;

   typedef struct {
      logic       rdy;
      logic       rv;
      logic [6:0] rpc;
      logic       ev;
      logic [6:0] epc;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t vq[$];
   logic [31:0] mem [0:127];

   always #5 clk = ~clk;

   drap_ifetch_if bus ();

   drap_ifetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (bus.imem_write) begin
         mem[bus.imem_address] <= bus.imem_data_in;
      end
      bus.imem_data_out <= mem[bus.imem_address];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic rdy, input logic rv, input logic [6:0] rpc,
                               input logic ev, input logic [6:0] epc);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
      vq.push_back(v);
   endfunction

   function automatic void add_run(input int start, input int n);
      for (int i = 0; i < n; i++) add(1'b1, 1'b0, 7'd0, 1'b1, 7'(start + i));
   endfunction

   task automatic check_out(input string nm, input logic ev, input logic [6:0] epc);
      chk({nm, "_valid"}, 32'(bus.instr_valid), 32'(ev));
      chk({nm, "_pc"},    32'(bus.instr_pc),    ev ? 32'(epc) : 32'd0);
      chk({nm, "_instr"}, bus.instr,            ev ? 32'hA000_0000 + 32'(epc) : 32'd0);
   endtask

   initial begin
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 7'd0;
`ifdef IFETCH_BOOTLOAD_EN
      bus.load_en   = 1'b0;
      bus.load_addr = 7'd0;
      bus.load_data = 32'd0;
`endif
      // Cycle-by-cycle vectors, cycle 0 is the first cycle after reset release.
      add(1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      add_run(0, 10);                                  // cycles 2..11: pcs 0..9
      for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 10); // stall at pc 10
      add_run(10, 10);                                 // 10..19, no gap or repeat
      add(0, 0, 0, 1, 20);                             // fill buffer with 20, 21
      add(0, 1, 64, 1, 20);                            // redirect while full
      add(1, 0, 0, 0, 0);
      add_run(64, 2);
      add(1, 1, 5, 1, 66);                             // redirect to 5 ...
      add(1, 1, 90, 0, 0);                             // ... overridden by 90
      add(1, 0, 0, 0, 0);
      add_run(90, 3);
      add(1, 1, 124, 1, 93);
      add(1, 0, 0, 0, 0);
      add_run(124, 4);                                 // 124..127
      add_run(0, 3);                                   // wrap to 0, 1, 2

      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_pc", 32'(bus.instr_pc), 32'd0);
      chk("rst_addr", 32'(bus.imem_address), 32'd0);
      chk("rst_write", 32'(bus.imem_write), 32'd0);
      chk("rst_wdata", bus.imem_data_in, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < vq.size(); k++) begin
         bus.instr_ready    = vq[k].rdy;
         bus.redirect_valid = vq[k].rv;
         bus.redirect_pc    = vq[k].rpc;
         #1;
         check_out($sformatf("vec%0d", k), vq[k].ev, vq[k].epc);
         if (vq[k].rv) chk($sformatf("vec%0d_raddr", k), 32'(bus.imem_address), 32'(vq[k].rpc));
         @(negedge clk);
      end

      // Asynchronous reset mid-stream, checked before the next rising edge.
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_valid", 32'(bus.instr_valid), 32'd0);
      chk("async_instr", bus.instr, 32'd0);
      chk("async_pc", 32'(bus.instr_pc), 32'd0);
      chk("async_addr", 32'(bus.imem_address), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_out($sformatf("rerst%0d", c), c >= 2, 7'(c - 2));
         @(negedge clk);
      end

`ifdef IFETCH_BOOTLOAD_EN
      bus.load_en   = 1'b1;
      bus.load_addr = 7'd0;
      bus.load_data = 32'h5555_5555;
      #1;
      chk("load_valid", 32'(bus.instr_valid), 32'd0);
      chk("load_write", 32'(bus.imem_write), 32'd1);
      chk("load_addr0", 32'(bus.imem_address), 32'd0);
      chk("load_wdata", bus.imem_data_in, 32'h5555_5555);
      @(negedge clk);
      bus.load_addr = 7'd127;
      bus.load_data = 32'hAAAA_AAAA;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 7'd50;
      #1;
      chk("load_addr127", 32'(bus.imem_address), 32'd127);
      chk("load_valid2", 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.load_en = 1'b0;
      #1;
      for (int k = 0; k < 10 && !bus.instr_valid; k++) begin
         @(negedge clk);
         #1;
      end
      chk("boot_restart_valid", 32'(bus.instr_valid), 32'd1);
      chk("boot_restart_pc", 32'(bus.instr_pc), 32'd0);
      chk("boot_restart_instr", bus.instr, 32'h5555_5555);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 7'd127;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      for (int k = 0; k < 10 && !bus.instr_valid; k++) begin
         @(negedge clk);
         #1;
      end
      chk("boot_127_valid", 32'(bus.instr_valid), 32'd1);
      chk("boot_127_pc", 32'(bus.instr_pc), 32'd127);
      chk("boot_127_instr", bus.instr, 32'hAAAA_AAAA);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
